shift_pipe: RTL and testbench

- Two-stage pipelined 32-bit shifter for the execute stage; it sits between the decode/operand-select logic and the ALU result mux.
- Performs SLL, SRL and SRA by a 5-bit shift amount using a log-shifter ladder of 16/8/4/2/1 stages.
- The coarse stages (16, 8) run in stage 1; the fine stages (4, 2, 1) run in stage 2.
- Valid/ready handshake on both sides. Throughput is one op per cycle; latency is 2 cycles.

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_stage.sv | 32 +++
 rtl/shift_pipe.sv | 110 +++++++++++
 tb/tb_shift_pipe.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared constants and op encodings for the pipelined shifter.
//   WIDTH   - datapath width (only 32 is supported)
//   SHAMT_W - shift-amount width derived from WIDTH
//   op_e    - shift operation encoding carried on the op ports
package shift_pkg;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRA  = 2'b01,
        OP_SRL  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

endpackage

// File: rtl/shift_stage.sv
// shift_stage: one rung of the log-shifter ladder (purely combinational).
//   AMT    - fixed shift distance of this rung (16/8/4/2/1)
//   data   - in : operand from the previous rung
//   enable - in : apply this rung's shift
//   op     - in : shift operation (SLL/SRA/SRL/reserved)
//   result - out: shifted operand for the next rung
import shift_pkg::*;

module shift_stage #(
    parameter int unsigned AMT = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             enable,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result
);

    // SRA replicates data[WIDTH-1]; earlier rungs never change the MSB under
    // SRA, so this is always the sign of the original operand.
    always_comb begin
        result = data;
        if (enable) begin
            case (op_e'(op))
                OP_SLL:  result = data << AMT;
                OP_SRL:  result = data >> AMT;
                OP_SRA:  result = WIDTH'($signed(data) >>> AMT);
                default: result = data;
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: two-stage pipelined 32-bit SLL/SRA/SRL shifter with
// valid/ready handshakes on both sides; one op per cycle, 2-cycle latency.
//   SPLIT     - number of high shamt bits applied in stage 1
//   clock     - in : rising-edge clock
//   reset     - in : asynchronous active-high reset
//   in_valid  - in : upstream has an op
//   in_ready  - out: op can be accepted this cycle
//   data_in   - in : operand
//   shamt     - in : shift amount 0..31
//   op        - in : 00=SLL, 01=SRA, 10=SRL, 11=reserved
//   out_valid - out: result available
//   out_ready - in : downstream accepts the result
//   data_out  - out: shifted result
//   out_err   - out: result came from a reserved op (data passed unshifted)
import shift_pkg::*;

module shift_pipe #(
    parameter int unsigned SPLIT = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [4:0]       shamt,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             out_err
);

    localparam int unsigned LO_W = SHAMT_W - SPLIT;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic [LO_W-1:0]  s1_shamt;
    op_e              s1_op;
    logic             s1_err;
    logic             s2_valid;

    logic             accept;
    logic             s2_adv;

    // Rung chains: index 0 is the stage input, index N the stage output.
    logic [WIDTH-1:0] c1 [SPLIT+1];
    logic [WIDTH-1:0] c2 [LO_W+1];

    assign s2_adv    = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || s2_adv;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    // Stage 1: largest rungs first, driven by the high shamt bits.
    assign c1[0] = data_in;
    for (genvar k = 0; k < SPLIT; k++) begin : g_s1
        localparam int unsigned B = SHAMT_W - 1 - k;
        shift_stage #(.AMT(1 << B)) u_stage (
            .data   (c1[k]),
            .enable (shamt[B]),
            .op     (op),
            .result (c1[k+1])
        );
    end

    // Stage 2: remaining rungs, driven by the registered low shamt bits.
    assign c2[0] = s1_data;
    for (genvar k = 0; k < LO_W; k++) begin : g_s2
        localparam int unsigned B = LO_W - 1 - k;
        shift_stage #(.AMT(1 << B)) u_stage (
            .data   (c2[k]),
            .enable (s1_shamt[B]),
            .op     (s1_op),
            .result (c2[k+1])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_shamt <= '0;
            s1_op    <= OP_SLL;
            s1_err   <= 1'b0;
            s2_valid <= 1'b0;
            data_out <= '0;
            out_err  <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_data  <= c1[SPLIT];
                s1_shamt <= shamt[LO_W-1:0];
                s1_op    <= op_e'(op);
                s1_err   <= (op == OP_RSVD);
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end

            // Data registers load only on advance, so a stalled result holds.
            if (s2_adv) begin
                s2_valid <= 1'b1;
                data_out <= c2[LO_W];
                out_err  <= s1_err;
            end else if (out_ready && s2_valid) begin
                s2_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_pipe.sv
import shift_pkg::*;

module tb_shift_pipe;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic        out_err;

    int total = 0;
    int bad   = 0;

    shift_pipe #(.SPLIT(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .shamt     (shamt),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_err   (out_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Single op through an empty pipeline with out_ready=1.
    task automatic run_one(input string tag, input logic [1:0] o, input logic [31:0] d,
                           input logic [4:0] s, input logic [31:0] exp, input logic exp_err);
        in_valid = 1'b1; op = o; data_in = d; shamt = s;
        #1;
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0; data_in = 32'hA5A5_A5A5; shamt = 5'd17; op = OP_SLL;
        #1;
        check({tag, "_v1"}, {31'd0, out_valid}, 32'd0);
        tick();
        #1;
        check({tag, "_v2"}, {31'd0, out_valid}, 32'd1);
        check(tag, data_out, exp);
        check({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
        tick();
    endtask

    logic [1:0]  s_op  [8];
    logic [31:0] s_dat [8];
    logic [4:0]  s_sh  [8];
    logic [31:0] s_exp [8];

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        data_in = '0; shamt = '0; op = OP_SLL;

        // Reset state
        tick(); tick();
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data",  data_out, 32'd0);
        check("rst_err",   {31'd0, out_err}, 32'd0);
        reset = 1'b0;
        #1;
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        tick();

        // Basic ops
        run_one("sra4",     OP_SRA, 32'h8000_0010, 5'd4,  32'hF800_0001, 1'b0);
        run_one("srl4",     OP_SRL, 32'h8000_0010, 5'd4,  32'h0800_0001, 1'b0);
        run_one("sll31",    OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
        run_one("sll12",    OP_SLL, 32'h0000_ABCD, 5'd12, 32'h0ABC_D000, 1'b0);
        run_one("srl20",    OP_SRL, 32'h1234_5678, 5'd20, 32'h0000_0123, 1'b0);
        run_one("sra9",     OP_SRA, 32'h8000_0000, 5'd9,  32'hFFC0_0000, 1'b0);
        // Boundaries
        run_one("sra0",     OP_SRA, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0);
        run_one("sll0",     OP_SLL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0);
        run_one("sra31",    OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0);
        run_one("sra31pos", OP_SRA, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b0);
        run_one("srl31",    OP_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0);
        run_one("sll31f",   OP_SLL, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b0);
        run_one("srl16",    OP_SRL, 32'hFFFF_FFFF, 5'd16, 32'h0000_FFFF, 1'b0);
        // Reserved op, then a normal op clears the error flag
        run_one("rsvd",     OP_RSVD, 32'h1234_5678, 5'd7, 32'h1234_5678, 1'b1);
        run_one("after_rsvd", OP_SLL, 32'h0000_0001, 5'd1, 32'h0000_0002, 1'b0);

        // Back-to-back stream: result of op c-2 is visible after edge c
        s_op[0] = OP_SLL; s_dat[0] = 32'h0000_0001; s_sh[0] = 5'd1;  s_exp[0] = 32'h0000_0002;
        s_op[1] = OP_SRL; s_dat[1] = 32'h8000_0000; s_sh[1] = 5'd3;  s_exp[1] = 32'h1000_0000;
        s_op[2] = OP_SRA; s_dat[2] = 32'h8000_0000; s_sh[2] = 5'd3;  s_exp[2] = 32'hF000_0000;
        s_op[3] = OP_SLL; s_dat[3] = 32'h0000_000F; s_sh[3] = 5'd28; s_exp[3] = 32'hF000_0000;
        s_op[4] = OP_SRL; s_dat[4] = 32'hF000_0000; s_sh[4] = 5'd28; s_exp[4] = 32'h0000_000F;
        s_op[5] = OP_SRA; s_dat[5] = 32'h4000_0000; s_sh[5] = 5'd30; s_exp[5] = 32'h0000_0001;
        s_op[6] = OP_SLL; s_dat[6] = 32'h1234_5678; s_sh[6] = 5'd4;  s_exp[6] = 32'h2345_6780;
        s_op[7] = OP_SRA; s_dat[7] = 32'hFFFF_FF00; s_sh[7] = 5'd8;  s_exp[7] = 32'hFFFF_FFFF;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                in_valid = 1'b1; op = s_op[c]; data_in = s_dat[c]; shamt = s_sh[c];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 8) check($sformatf("strm_rdy%0d", c), {31'd0, in_ready}, 32'd1);
            if (c >= 2) begin
                check($sformatf("strm_v%0d", c - 2), {31'd0, out_valid}, 32'd1);
                check($sformatf("strm_d%0d", c - 2), data_out, s_exp[c-2]);
            end else begin
                check($sformatf("strm_idle%0d", c), {31'd0, out_valid}, 32'd0);
            end
            tick();
        end
        #1;
        check("strm_drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: two accepts, then stall with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1; op = OP_SRL; data_in = 32'h0000_F000; shamt = 5'd12;
        #1;
        check("bp_rdy0", {31'd0, in_ready}, 32'd1);
        tick();
        op = OP_SLL; data_in = 32'h0000_0003; shamt = 5'd5;
        #1;
        check("bp_rdy1", {31'd0, in_ready}, 32'd1);
        tick();
        op = OP_SRA; data_in = 32'h8000_0000; shamt = 5'd1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp_stall_rdy%0d", c), {31'd0, in_ready}, 32'd0);
            check($sformatf("bp_stall_v%0d", c), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp_stall_d%0d", c), data_out, 32'h0000_000F);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("bp_rel_d0", data_out, 32'h0000_000F);
        tick();
        #1;
        check("bp_rel_v1", {31'd0, out_valid}, 32'd1);
        check("bp_rel_d1", data_out, 32'h0000_0060);
        tick();
        #1;
        check("bp_rel_empty", {31'd0, out_valid}, 32'd0);
        tick();

        // Reset with a full pipeline (reserved op in stage 2)
        out_ready = 1'b0;
        in_valid = 1'b1; op = OP_RSVD; data_in = 32'hAAAA_5555; shamt = 5'd3;
        tick();
        op = OP_SLL; data_in = 32'h0000_0001; shamt = 5'd4;
        tick();
        in_valid = 1'b0;
        #1;
        check("rf_full_v",   {31'd0, out_valid}, 32'd1);
        check("rf_full_err", {31'd0, out_err}, 32'd1);
        check("rf_full_d",   data_out, 32'hAAAA_5555);
        #1;
        reset = 1'b1;
        #1;
        check("rf_v",    {31'd0, out_valid}, 32'd0);
        check("rf_d",    data_out, 32'd0);
        check("rf_err",  {31'd0, out_err}, 32'd0);
        tick();
        reset = 1'b0; out_ready = 1'b1;
        #1;
        check("rf_rdy", {31'd0, in_ready}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            check($sformatf("rf_stale%0d", c), {31'd0, out_valid}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
